cpu_pipe_ctrl: RTL and testbench

Pipeline control unit for the five-stage CPU (IF/ID/EX/MEM/WB). It merges the stall sources (instruction-fetch busy, load hazard from the decoder, memory busy) into per-stage stall/flush strobes. It owns the control registers read by RDCR and written by WRCR. It sequences exception entry, exception return (EXRT) and the post-WRCR refetch from the instruction committing in MEM, and supplies the redirect PC to IF.

---
 rtl/cpu_pipe_ctrl_pkg.sv | 31 +++
 rtl/cpu_creg_file.sv | 60 ++++++
 rtl/cpu_pipe_ctrl.sv | 76 +++++++
 tb/tb_cpu_pipe_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_ctrl_pkg.sv
// cpu_pipe_ctrl_pkg: shared encodings for the pipeline control unit and its control registers.
package cpu_pipe_ctrl_pkg;
  typedef enum logic [2:0] {
    EXP_NONE     = 3'd0,
    EXP_EXT_INT  = 3'd1,
    EXP_UNDEF    = 3'd2,
    EXP_OVERFLOW = 3'd3,
    EXP_MISALIGN = 3'd4,
    EXP_TRAP     = 3'd5,
    EXP_PRIV_VIO = 3'd6
  } exp_code_e;
  typedef enum logic [1:0] {
    CTRL_NOP  = 2'd0,
    CTRL_WRCR = 2'd1,
    CTRL_EXRT = 2'd2
  } ctrl_op_e;
  typedef enum logic [4:0] {
    CREG_STATUS     = 5'd0,
    CREG_PRE_STATUS = 5'd1,
    CREG_INT_MASK   = 5'd3,
    CREG_EXP_CODE   = 5'd4,
    CREG_EXP_VECTOR = 5'd5,
    CREG_EPC        = 5'd6
  } creg_addr_e;
  localparam logic EXE_KERNEL = 1'b0;
  localparam logic EXE_USER   = 1'b1;
  typedef struct packed {
    logic int_en;
    logic exe_mode;
  } status_t;
endpackage

// File: rtl/cpu_creg_file.sv
// cpu_creg_file: control register storage with RDCR read mux, WRCR write port and exception/EXRT updates.
module cpu_creg_file
  import cpu_pipe_ctrl_pkg::*;
#(
  parameter int IRQ_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [31:0]      wr_data,
  input  logic             exp_en,
  input  logic [2:0]       exp_code,
  input  logic [29:0]      exp_epc,
  input  logic             exrt_en,
  input  logic [4:0]       rd_addr,
  output logic [31:0]      rd_data,
  output status_t          status,
  output logic [IRQ_W-1:0] int_mask,
  output logic [29:0]      exp_vector,
  output logic [29:0]      epc
);
  status_t    pre_status;
  logic [2:0] exp_code_r;
  always_ff @(posedge clk) begin
    if (reset) begin
      status     <= '{int_en: 1'b0, exe_mode: EXE_KERNEL};
      pre_status <= '{int_en: 1'b0, exe_mode: EXE_KERNEL};
      int_mask   <= '1;
      exp_code_r <= '0;
      exp_vector <= '0;
      epc        <= '0;
    end else if (exp_en) begin
      exp_code_r <= exp_code;
      epc        <= exp_epc;
      pre_status <= status;
      status     <= '{int_en: 1'b0, exe_mode: EXE_KERNEL};
    end else if (exrt_en) begin
      status <= pre_status;
    end else if (wr_en) begin
      case (wr_addr)
        CREG_STATUS:     status     <= status_t'(wr_data[1:0]);
        CREG_PRE_STATUS: pre_status <= status_t'(wr_data[1:0]);
        CREG_INT_MASK:   int_mask   <= wr_data[IRQ_W-1:0];
        CREG_EXP_CODE:   exp_code_r <= wr_data[2:0];
        CREG_EXP_VECTOR: exp_vector <= wr_data[31:2];
        CREG_EPC:        epc        <= wr_data[31:2];
        default: ;
      endcase
    end
  end
  always_comb begin
    rd_data = rd_addr == CREG_STATUS     ? 32'(status) :
              rd_addr == CREG_PRE_STATUS ? 32'(pre_status) :
              rd_addr == CREG_INT_MASK   ? 32'(int_mask) :
              rd_addr == CREG_EXP_CODE   ? 32'(exp_code_r) :
              rd_addr == CREG_EXP_VECTOR ? {exp_vector, 2'b00} :
              rd_addr == CREG_EPC        ? {epc, 2'b00} : 32'd0;
  end
endmodule

// File: rtl/cpu_pipe_ctrl.sv
// cpu_pipe_ctrl: merges stall sources into per-stage stall/flush strobes and sequences MEM-stage events.
module cpu_pipe_ctrl
  import cpu_pipe_ctrl_pkg::*;
#(
  parameter int IRQ_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_busy,
  input  logic             ld_hazard,
  input  logic             mem_busy,
  input  logic [IRQ_W-1:0] irq,
  input  logic             mem_en,
  input  logic [29:0]      mem_pc,
  input  logic             mem_br_flag,
  input  logic [1:0]       mem_ctrl_op,
  input  logic [4:0]       mem_dst_addr,
  input  logic [31:0]      mem_out,
  input  logic [2:0]       mem_exp_code,
  input  logic [4:0]       creg_rd_addr,
  output logic [31:0]      creg_rd_data,
  output logic             exe_mode,
  output logic             int_detect,
  output logic             if_stall,
  output logic             id_stall,
  output logic             ex_stall,
  output logic             mem_stall,
  output logic             if_flush,
  output logic             id_flush,
  output logic             ex_flush,
  output logic             mem_flush,
  output logic [29:0]      new_pc
);
  status_t          status;
  logic [IRQ_W-1:0] int_mask;
  logic [29:0]      exp_vector, epc, exp_epc;
  logic             take, exp_ev, exrt_ev, wrcr_ev, flush, stall_any;
  // A held MEM event (mem_busy) is simply not taken; it fires once mem_busy drops.
  assign take    = ~reset & mem_en & ~mem_busy;
  assign exp_ev  = take & (mem_exp_code != EXP_NONE);
  assign exrt_ev = take & ~exp_ev & (mem_ctrl_op == CTRL_EXRT);
  assign wrcr_ev = take & ~exp_ev & (mem_ctrl_op == CTRL_WRCR);
  assign flush   = exp_ev | exrt_ev | wrcr_ev;
  always_comb begin
    stall_any = ~reset & ~flush & (if_busy | ld_hazard | mem_busy);
    if_stall  = stall_any;
    id_stall  = stall_any;
    ex_stall  = ~reset & ~flush & mem_busy;
    mem_stall = ~reset & ~flush & mem_busy;
    if_flush  = flush;
    id_flush  = flush | (~reset & ld_hazard & ~if_busy & ~mem_busy);
    ex_flush  = flush;
    mem_flush = flush;
    new_pc    = exp_ev ? exp_vector : exrt_ev ? epc : wrcr_ev ? mem_pc + 30'd1 : 30'd0;
    exp_epc   = mem_br_flag ? mem_pc - 30'd1 : mem_pc;
  end
  assign exe_mode   = status.exe_mode;
  assign int_detect = status.int_en & |(irq & ~int_mask);
  cpu_creg_file #(.IRQ_W(IRQ_W)) u_creg (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wrcr_ev),
    .wr_addr    (mem_dst_addr),
    .wr_data    (mem_out),
    .exp_en     (exp_ev),
    .exp_code   (mem_exp_code),
    .exp_epc    (exp_epc),
    .exrt_en    (exrt_ev),
    .rd_addr    (creg_rd_addr),
    .rd_data    (creg_rd_data),
    .status     (status),
    .int_mask   (int_mask),
    .exp_vector (exp_vector),
    .epc        (epc)
  );
endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// tb_cpu_pipe_ctrl: scoreboard bench; driver pushes reference-model expectations, monitor pops and compares.
module tb_cpu_pipe_ctrl;
  localparam int IRQ_W = 8;
  typedef struct packed {
    logic        rst;
    logic        if_busy;
    logic        ld;
    logic        mb;
    logic [7:0]  irq;
    logic        en;
    logic [29:0] pc;
    logic        br;
    logic [1:0]  op;
    logic [4:0]  dst;
    logic [31:0] out;
    logic [2:0]  code;
    logic [4:0]  rd;
  } stim_t;
  typedef struct packed {
    logic [3:0]  stall;
    logic [3:0]  flush;
    logic [29:0] new_pc;
    logic        int_det;
    logic        exe_mode;
    logic [31:0] rd_data;
  } exp_t;
  logic clk = 1'b0, reset, if_busy, ld_hazard, mem_busy, mem_en, mem_br_flag;
  logic [IRQ_W-1:0] irq;
  logic [29:0] mem_pc, new_pc;
  logic [1:0]  mem_ctrl_op;
  logic [4:0]  mem_dst_addr, creg_rd_addr;
  logic [31:0] mem_out, creg_rd_data;
  logic [2:0]  mem_exp_code;
  logic exe_mode, int_detect, if_stall, id_stall, ex_stall, mem_stall;
  logic if_flush, id_flush, ex_flush, mem_flush;
  int n_chk = 0, n_fail = 0;
  exp_t q[$];
  exp_t me;
  logic [31:0] creg [8];
  always #5 clk = ~clk;
  cpu_pipe_ctrl #(.IRQ_W(IRQ_W)) dut (
    .clk(clk), .reset(reset), .if_busy(if_busy), .ld_hazard(ld_hazard), .mem_busy(mem_busy),
    .irq(irq), .mem_en(mem_en), .mem_pc(mem_pc), .mem_br_flag(mem_br_flag),
    .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr), .mem_out(mem_out),
    .mem_exp_code(mem_exp_code), .creg_rd_addr(creg_rd_addr), .creg_rd_data(creg_rd_data),
    .exe_mode(exe_mode), .int_detect(int_detect), .if_stall(if_stall), .id_stall(id_stall),
    .ex_stall(ex_stall), .mem_stall(mem_stall), .if_flush(if_flush), .id_flush(id_flush),
    .ex_flush(ex_flush), .mem_flush(mem_flush), .new_pc(new_pc)
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask
  function automatic logic [31:0] wmask(input int a);
    case (a)
      0, 1:    return 32'h3;
      3:       return 32'hFF;
      4:       return 32'h7;
      5, 6:    return 32'hFFFF_FFFC;
      default: return 32'h0;
    endcase
  endfunction
  function automatic stim_t idle();
    stim_t s = '0;
    return s;
  endfunction
  function automatic stim_t ev(input logic [1:0] op, input logic [2:0] code, input logic [29:0] pc,
                               input logic [4:0] dst, input logic [31:0] out);
    stim_t s = '0;
    s.en = 1'b1; s.op = op; s.code = code; s.pc = pc; s.dst = dst; s.out = out;
    return s;
  endfunction
  function automatic stim_t rnd();
    stim_t s = '0;
    int r;
    s.rst = $urandom_range(0, 99) == 0;
    s.if_busy = $urandom_range(0, 3) == 0;
    s.ld = $urandom_range(0, 3) == 0;
    s.mb = $urandom_range(0, 3) == 0;
    s.irq = 8'($urandom);
    s.en = $urandom_range(0, 2) != 0;
    r = $urandom_range(0, 9);
    s.pc = r == 0 ? 30'd0 : r == 1 ? 30'h3FFF_FFFF : 30'($urandom);
    s.br = 1'($urandom);
    s.op = 2'($urandom);
    s.dst = 5'($urandom_range(0, 8));
    s.out = $urandom;
    s.code = $urandom_range(0, 3) == 0 ? 3'($urandom_range(1, 7)) : 3'd0;
    s.rd = 5'($urandom_range(0, 8));
    return s;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 8; i++) creg[i] = 32'd0;
    creg[3] = 32'hFF;
  endtask
  task automatic apply(input stim_t s);
    exp_t e;
    logic take;
    logic [29:0] pc1;
    @(posedge clk);
    #1;
    reset = s.rst; if_busy = s.if_busy; ld_hazard = s.ld; mem_busy = s.mb; irq = s.irq;
    mem_en = s.en; mem_pc = s.pc; mem_br_flag = s.br; mem_ctrl_op = s.op;
    mem_dst_addr = s.dst; mem_out = s.out; mem_exp_code = s.code; creg_rd_addr = s.rd;
    e = '0;
    e.int_det = creg[0][1] && ((s.irq & ~creg[3][7:0]) != 8'd0);
    e.exe_mode = creg[0][0];
    e.rd_data = s.rd < 8 ? creg[s.rd[2:0]] : 32'd0;
    take = !s.rst && s.en && !s.mb;
    if (s.rst) begin
      e.stall = 4'h0;
    end else if (take && (s.code != 0 || s.op == 2'd1 || s.op == 2'd2)) begin
      e.flush = 4'hF;
      e.new_pc = s.code != 0 ? creg[5][31:2] : s.op == 2'd2 ? creg[6][31:2] : s.pc + 30'd1;
    end else begin
      e.stall = {{2{s.if_busy | s.ld | s.mb}}, {2{s.mb}}};
      e.flush = {1'b0, s.ld & ~s.if_busy & ~s.mb, 2'b00};
    end
    q.push_back(e);
    if (s.rst) model_reset();
    else if (take && s.code != 0) begin
      pc1 = s.br ? s.pc - 30'd1 : s.pc;
      creg[4] = 32'(s.code);
      creg[6] = {pc1, 2'b00};
      creg[1] = creg[0];
      creg[0] = 32'd0;
    end else if (take && s.op == 2'd2) creg[0] = creg[1];
    else if (take && s.op == 2'd1 && s.dst < 8) creg[s.dst[2:0]] = s.out & wmask(int'(s.dst));
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      me = q.pop_front();
      chk("stalls", 32'({if_stall, id_stall, ex_stall, mem_stall}), 32'(me.stall));
      chk("flushes", 32'({if_flush, id_flush, ex_flush, mem_flush}), 32'(me.flush));
      chk("new_pc", 32'(new_pc), 32'(me.new_pc));
      chk("int_detect", 32'(int_detect), 32'(me.int_det));
      chk("exe_mode", 32'(exe_mode), 32'(me.exe_mode));
      chk("creg_rd_data", creg_rd_data, me.rd_data);
    end
  end
  initial begin
    stim_t s;
    reset = 1'b1; if_busy = 0; ld_hazard = 0; mem_busy = 0; irq = '0; mem_en = 0; mem_pc = '0;
    mem_br_flag = 0; mem_ctrl_op = '0; mem_dst_addr = '0; mem_out = '0; mem_exp_code = '0;
    creg_rd_addr = '0;
    repeat (2) @(posedge clk);
    model_reset();
    s = idle(); s.rst = 1'b1; s.rd = 5'd3; apply(s);
    @(negedge clk); chk("reset if_stall", 32'(if_stall), 0);
    s = idle(); s.ld = 1'b1; apply(s);
    @(negedge clk); chk("ld stalls", 32'({if_stall, id_stall, ex_stall, mem_stall}), 32'hC);
    chk("ld id_flush", 32'(id_flush), 1);
    s.mb = 1'b1; apply(s);
    @(negedge clk); chk("ld+mb stalls", 32'({if_stall, id_stall, ex_stall, mem_stall}), 32'hF);
    chk("ld+mb id_flush", 32'(id_flush), 0);
    apply(ev(2'd1, 3'd0, 30'h10, 5'd0, 32'h3));
    s = ev(2'd1, 3'd0, 30'h11, 5'd3, 32'hFE); s.irq = 8'h01; apply(s);
    @(negedge clk); chk("wrcr mask new_pc", 32'(new_pc), 32'h12);
    chk("wrcr mask int_detect before", 32'(int_detect), 0);
    s = idle(); s.irq = 8'h01; apply(s);
    @(negedge clk); chk("int_detect after mask", 32'(int_detect), 1);
    apply(ev(2'd1, 3'd0, 30'h12, 5'd5, 32'h100));
    s = ev(2'd0, 3'd2, 30'h100, 5'd0, 32'd0); s.br = 1'b1; apply(s);
    @(negedge clk); chk("exp new_pc", 32'(new_pc), 32'h40);
    chk("exp flush", 32'({if_flush, id_flush, ex_flush, mem_flush}), 32'hF);
    s = idle(); s.rd = 5'd6; apply(s);
    @(negedge clk); chk("exp epc", creg_rd_data, 32'h3FC);
    chk("exp exe_mode", 32'(exe_mode), 0);
    s.rd = 5'd1; apply(s);
    @(negedge clk); chk("exp pre_status", creg_rd_data, 32'h3);
    s.rd = 5'd4; apply(s);
    @(negedge clk); chk("exp code", creg_rd_data, 32'h2);
    apply(ev(2'd2, 3'd0, 30'h200, 5'd0, 32'd0));
    @(negedge clk); chk("exrt new_pc", 32'(new_pc), 32'hFF);
    apply(idle());
    @(negedge clk); chk("exrt exe_mode", 32'(exe_mode), 1);
    for (int i = 0; i < 4; i++) begin
      s = ev(2'd0, 3'd3, 30'h300, 5'd0, 32'd0); s.mb = i < 3; apply(s);
      @(negedge clk); chk("busy exp flush", 32'(if_flush), i < 3 ? 0 : 1);
    end
    s = ev(2'd1, 3'd0, 30'h20, 5'd6, 32'h1234); s.rst = 1'b1; apply(s);
    @(negedge clk); chk("reset wrcr flush", 32'(if_flush), 0);
    chk("reset wrcr new_pc", 32'(new_pc), 0);
    s = idle(); s.rd = 5'd6; apply(s);
    @(negedge clk); chk("reset epc", creg_rd_data, 0);
    s.rd = 5'd3; apply(s);
    @(negedge clk); chk("reset int_mask", creg_rd_data, 32'hFF);
    apply(ev(2'd1, 3'd0, 30'h3FFF_FFFF, 5'd2, 32'h55));
    @(negedge clk); chk("wrap new_pc", 32'(new_pc), 0);
    s = ev(2'd0, 3'd5, 30'd0, 5'd0, 32'd0); s.br = 1'b1; apply(s);
    s = idle(); s.rd = 5'd6; apply(s);
    @(negedge clk); chk("wrap epc", creg_rd_data, 32'hFFFF_FFFC);
    for (int i = 0; i < 3000; i++) apply(rnd());
    repeat (2) @(negedge clk);
    chk("queue drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
